// File: rtl/fpga_soc_reset_sequencer.sv
// Board reset/boot sequencer for the CB_heep SoC: waits for stable PLL lock, holds reset, latches straps, captures exit.
// Optional auto-restart of EXITED runs is compiled in with `define SOC_RESET_SEQ_AUTO_RESTART_EN.
module fpga_soc_reset_sequencer #(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int HOLD_CYCLES        = 64,
  parameter int BLINK_BIT          = 24
`ifdef SOC_RESET_SEQ_AUTO_RESTART_EN
  , parameter int RESTART_CYCLES   = 1024
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pll_locked_i,
  input  logic        boot_select_i,
  input  logic        execute_from_flash_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        soc_rst_no,
  output logic        boot_select_o,
  output logic        execute_from_flash_o,
  output logic        exit_done_o,
  output logic [31:0] exit_code_o,
  output logic        status_led_o,
  output logic [2:0]  state_o
);

  localparam int LW = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam int BW = BLINK_BIT + 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
`ifdef SOC_RESET_SEQ_AUTO_RESTART_EN
  localparam int RW = $clog2(RESTART_CYCLES) + 1;
  localparam logic [RW-1:0] RESTART_LAST = RW'(RESTART_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    HOLD      = 3'd1,
    RUN       = 3'd2,
    EXITED    = 3'd3
  } state_e;

  state_e state, state_d;

  logic [LW-1:0] lock_cnt, lock_cnt_d;
  logic [HW-1:0] hold_cnt, hold_cnt_d;
  logic [BW-1:0] blink_cnt, blink_cnt_d;
`ifdef SOC_RESET_SEQ_AUTO_RESTART_EN
  logic [RW-1:0] restart_cnt, restart_cnt_d;
`endif

  logic        soc_rst_n_d, led_d, boot_sel_d, exec_flash_d, exit_done_d;
  logic [31:0] exit_code_d;

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) state <= WAIT_LOCK;
    else       state <= state_d;
  end

  // Next-state logic; lock loss outranks every other transition out of HOLD/RUN/EXITED
  always_comb begin
    // NOTE: a default assignment up front keeps every path assigned, so no latch is inferred.
    state_d = state;
    case (state)
      WAIT_LOCK: if (pll_locked_i && lock_cnt == LOCK_LAST) state_d = HOLD;
      HOLD: begin
        if (!pll_locked_i)              state_d = WAIT_LOCK;
        else if (hold_cnt == HOLD_LAST) state_d = RUN;
      end
      RUN: begin
        if (!pll_locked_i)     state_d = WAIT_LOCK;
        else if (exit_valid_i) state_d = EXITED;
      end
      EXITED: begin
        if (!pll_locked_i) state_d = WAIT_LOCK;
`ifdef SOC_RESET_SEQ_AUTO_RESTART_EN
        else if (restart_cnt == RESTART_LAST) state_d = HOLD;
`endif
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Output/datapath next values, derived from the upcoming state so outputs line up with state_o
  always_comb begin
    lock_cnt_d    = (state == WAIT_LOCK && pll_locked_i) ? lock_cnt + 1'b1 : '0;
    hold_cnt_d    = (state == HOLD) ? hold_cnt + 1'b1 : '0;
    blink_cnt_d   = blink_cnt + 1'b1;
`ifdef SOC_RESET_SEQ_AUTO_RESTART_EN
    restart_cnt_d = (state == EXITED) ? restart_cnt + 1'b1 : '0;
`endif
    boot_sel_d    = boot_select_o;
    exec_flash_d  = execute_from_flash_o;
    exit_done_d   = exit_done_o;
    exit_code_d   = exit_code_o;

    if (state == HOLD && state_d == RUN) begin
      boot_sel_d   = boot_select_i;
      exec_flash_d = execute_from_flash_i;
    end
    if (state == RUN && state_d == EXITED) begin
      exit_done_d = 1'b1;
      exit_code_d = exit_value_i;
    end
    if (state != WAIT_LOCK && state_d == WAIT_LOCK) begin
      exit_done_d = 1'b0;
      exit_code_d = '0;
    end

    soc_rst_n_d = (state_d == RUN) || (state_d == EXITED);

    led_d = 1'b0;
    case (state_d)
      HOLD:    led_d = 1'b1;
      RUN:     led_d = blink_cnt_d[BLINK_BIT];
      EXITED:  led_d = exit_code_d[0] ? blink_cnt_d[BLINK_BIT-2] : 1'b1;
      default: led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_cnt             <= '0;
      hold_cnt             <= '0;
      blink_cnt            <= '0;
`ifdef SOC_RESET_SEQ_AUTO_RESTART_EN
      restart_cnt          <= '0;
`endif
      soc_rst_no           <= 1'b0;
      boot_select_o        <= 1'b0;
      execute_from_flash_o <= 1'b0;
      exit_done_o          <= 1'b0;
      exit_code_o          <= '0;
      status_led_o         <= 1'b0;
    end else begin
      lock_cnt             <= lock_cnt_d;
      hold_cnt             <= hold_cnt_d;
      blink_cnt            <= blink_cnt_d;
`ifdef SOC_RESET_SEQ_AUTO_RESTART_EN
      restart_cnt          <= restart_cnt_d;
`endif
      soc_rst_no           <= soc_rst_n_d;
      boot_select_o        <= boot_sel_d;
      execute_from_flash_o <= exec_flash_d;
      exit_done_o          <= exit_done_d;
      exit_code_o          <= exit_code_d;
      status_led_o         <= led_d;
    end
  end

  assign state_o = state;

endmodule
